fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32: address/instruction width in bits.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset; bits [1:0] are zero.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 imem_addr  output  XLEN  current fetch PC presented to instruction memory.
REQ-007 imem_req  output  1  fetch request qualifier for imem_addr.
REQ-008 imem_rdata  input  XLEN  instruction word for imem_addr, same cycle.
REQ-009 imem_valid  input  1  imem_rdata valid this cycle; low means memory stall.
REQ-010 redirect_valid  input  1  taken jump/branch; flush and refetch.
REQ-011 redirect_addr  input  XLEN  jump/branch target.
REQ-012 stall  input  1  downstream not accepting; holds queue head.
REQ-013 out_valid  output  1  queue head valid.
REQ-014 out_instr  output  XLEN  queue head instruction.
REQ-015 out_pc  output  XLEN  PC of queue head instruction.
REQ-016 out_pc_step  output  XLEN  out_pc + 4, modulo 2^XLEN.
REQ-017 out_count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-018 imem_addr SHALL equal the PC register; imem_req = (count < DEPTH) & !redirect_valid.
REQ-019 Push SHALL occur when imem_req & imem_valid; entry = {imem_rdata, PC, PC+4}; PC advances by 4 next cycle.
REQ-020 PC SHALL hold when imem_valid is low or queue full; PC+4 wraps modulo 2^XLEN with no flag.
REQ-021 Pop SHALL occur when out_valid & !stall; head advances next cycle.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; both take effect.
REQ-023 Full (count == DEPTH): imem_req low, no push; a pop in that cycle frees a slot, imem_req rises the following cycle.
REQ-024 Empty (count == 0): out_valid low; out_instr/out_pc/out_pc_step hold last values; no pop.
REQ-025 Fetch-to-output latency SHALL be one cycle: a word pushed in cycle N is presented at the head in cycle N+1 if the queue was empty.
REQ-026 Read/write pointers SHALL be $clog2(DEPTH) bits, wrapping modulo DEPTH; full/empty derived from count.
REQ-027 redirect_valid SHALL, at the next edge: clear count and pointers, load PC = {redirect_addr[XLEN-1:2], 2'b00}, discard any same-cycle response and pop.
REQ-028 redirect_valid SHALL take priority over push, pop, full and stall in the same cycle.
REQ-029 redirect_valid on consecutive cycles SHALL use the last target; fetching resumes the cycle after redirect_valid falls.
REQ-030 out_valid SHALL be low in the cycle following a redirect.
REQ-031 Queue storage SHALL be registered; the head fields drive outputs directly from storage, with no combinational path from imem_rdata to out_*.

Reset
REQ-032 rst low SHALL asynchronously force PC = RESET_PC, count = 0, pointers = 0, out_valid = 0.
REQ-033 out_instr, out_pc and out_pc_step SHALL reset to 0; queue storage contents are don't-care.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries; first fetch after release is at RESET_PC.
REQ-035 imem_req SHALL be high in the first cycle after rst release, given redirect_valid low.

Verification
REQ-036 Reset release, imem_valid = 1, stall = 0 -> imem_addr 0,4,8,...; out_pc 0,4,8... one cycle behind; out_pc_step = out_pc+4.
REQ-037 DEPTH = 4, stall = 1, imem_valid = 1 -> four pushes, out_count = 4, imem_req low, PC = 0x10 held; stall released one cycle -> imem_req high next cycle.
REQ-038 Queue holding 3 entries, redirect_valid = 1 with redirect_addr = 0x103 -> next cycle out_count = 0, out_valid = 0, imem_addr = 0x100.
REQ-039 imem_valid toggling 1,0,1,0 -> PC advances only on valid cycles; no duplicate or dropped PCs at output.
REQ-040 RESET_PC = 0xFFFFFFF8, XLEN = 32 -> out_pc sequence FFFFFFF8, FFFFFFFC, 00000000; out_pc_step for FFFFFFFC = 00000000.
REQ-041 rst asserted asynchronously mid-clock with queue full -> outputs zero immediately; after release, first out_pc = RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential PC generator feeding a registered FIFO of
// {instruction, pc, pc+4} entries, with redirect flush and downstream stall.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [XLEN-1:0]          imem_addr,
    output logic                     imem_req,
    input  logic [XLEN-1:0]          imem_rdata,
    input  logic                     imem_valid,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_addr,
    input  logic                     stall,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_pc_step,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] pc_q, pc_d, pc_step;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d, remain;

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] step_mem  [DEPTH];

    logic [XLEN-1:0] head_instr_q, head_instr_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d;
    logic [XLEN-1:0] head_step_q, head_step_d;

    logic full, empty, push, pop;

    assign pc_step  = pc_q + XLEN'(4);
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign imem_req = !full && !redirect_valid;
    assign push     = imem_req && imem_valid;
    assign pop      = !empty && !stall && !redirect_valid;
    // Entries left in the queue after this cycle's pop, before the push lands.
    assign remain   = count_q - CW'(pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = redirect_addr & ~XLEN'(3);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_step;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Head registers load the next head entry; they hold while the queue is empty.
    always_comb begin
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        head_step_d  = head_step_q;
        if (!redirect_valid && count_d != '0) begin
            if (remain == '0) begin
                head_instr_d = imem_rdata;
                head_pc_d    = pc_q;
                head_step_d  = pc_step;
            end else begin
                head_instr_d = instr_mem[rd_ptr_d];
                head_pc_d    = pc_mem[rd_ptr_d];
                head_step_d  = step_mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            head_step_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            head_step_q  <= head_step_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]    <= pc_q;
            step_mem[wr_ptr_q]  <= pc_step;
        end
    end

    assign imem_addr   = pc_q;
    assign out_valid   = !empty;
    assign out_count   = count_q;
    assign out_instr   = head_instr_q;
    assign out_pc      = head_pc_q;
    assign out_pc_step = head_step_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle,
// directed boundary scenarios, then randomized traffic.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr, imem_rdata, redirect_addr;
    logic        imem_req, imem_valid, redirect_valid, stall;
    logic        out_valid;
    logic [31:0] out_instr, out_pc, out_pc_step;
    logic [2:0]  out_count;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .imem_valid     (imem_valid),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_step    (out_pc_step),
        .out_count      (out_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of fetched words, fetch PC, last-seen head fields.
    logic [31:0] m_instr[$];
    logic [31:0] m_pc[$];
    logic [31:0] m_fpc, m_hi, m_hp, m_hs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_instr.delete();
        m_pc.delete();
        m_fpc = RPC;
        m_hi  = '0;
        m_hp  = '0;
        m_hs  = '0;
    endtask

    task automatic check_model();
        chk("out_valid", 32'(out_valid), 32'(m_pc.size() > 0));
        chk("out_count", 32'(out_count), 32'(m_pc.size()));
        chk("imem_addr", imem_addr, m_fpc);
        chk("out_instr", out_instr, m_hi);
        chk("out_pc", out_pc, m_hp);
        chk("out_pc_step", out_pc_step, m_hs);
    endtask

    // One clock: drive at negedge, apply model at posedge, compare at next negedge.
    task automatic cycle(input logic rv, input logic [31:0] ra, input logic iv, input logic st);
        logic [31:0] rd;
        bit          req, do_pop;
        rd             = $urandom;
        redirect_valid = rv;
        redirect_addr  = ra;
        imem_valid     = iv;
        stall          = st;
        imem_rdata     = rd;
        #1;
        req = (m_pc.size() < DEPTH) && !rv;
        chk("imem_req", 32'(imem_req), 32'(req));
        @(posedge clk);
        if (rv) begin
            m_instr.delete();
            m_pc.delete();
            m_fpc = ra & 32'hFFFF_FFFC;
        end else begin
            do_pop = (m_pc.size() > 0) && !st;
            if (do_pop) begin
                void'(m_instr.pop_front());
                void'(m_pc.pop_front());
            end
            if (req && iv) begin
                m_instr.push_back(rd);
                m_pc.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
            end
        end
        if (m_pc.size() > 0) begin
            m_hi = m_instr[0];
            m_hp = m_pc[0];
            m_hs = m_pc[0] + 32'd4;
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        imem_rdata     = '0;
        imem_valid     = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        stall          = 1'b0;
        model_reset();

        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_step", out_pc_step, 32'd0);
        chk("rst_addr", imem_addr, RPC);
        rst = 1'b1;
        #1;
        chk("req_after_rst", 32'(imem_req), 32'd1);

        // Sequential fetch across the address wrap.
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("seq_pc0", out_pc, 32'hFFFF_FFF8);
        chk("seq_step0", out_pc_step, 32'hFFFF_FFFC);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("seq_pc1", out_pc, 32'hFFFF_FFFC);
        chk("seq_step1", out_pc_step, 32'h0000_0000);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("seq_pc2", out_pc, 32'h0000_0000);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("seq_pc3", out_pc, 32'h0000_0004);

        // Fill under stall, then release stall for one cycle.
        cycle(1'b1, 32'd0, 1'b1, 1'b0);
        chk("redir0_count", 32'(out_count), 32'd0);
        chk("redir0_valid", 32'(out_valid), 32'd0);
        chk("redir0_addr", imem_addr, 32'd0);
        repeat (4) cycle(1'b0, 32'd0, 1'b1, 1'b1);
        chk("full_count", 32'(out_count), 32'd4);
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_addr", imem_addr, 32'h10);
        cycle(1'b0, 32'd0, 1'b1, 1'b1);
        chk("full_hold_addr", imem_addr, 32'h10);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("unfull_count", 32'(out_count), 32'd3);
        chk("unfull_req", 32'(imem_req), 32'd1);
        chk("unfull_pc", out_pc, 32'h4);

        // Redirect with three entries queued; misaligned target.
        cycle(1'b1, 32'h103, 1'b1, 1'b0);
        chk("redir_count", 32'(out_count), 32'd0);
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_hold_pc", out_pc, 32'h4);

        // Memory stalls on alternate cycles.
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("tog_pc0", out_pc, 32'h100);
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        chk("tog_empty", 32'(out_valid), 32'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("tog_pc1", out_pc, 32'h104);
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        chk("tog_addr", imem_addr, 32'h108);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 16) == 0, $urandom, ($urandom % 4) != 0, ($urandom % 3) == 0);
        end

        // Asynchronous reset while full.
        repeat (5) cycle(1'b0, 32'd0, 1'b1, 1'b1);
        chk("pre_arst_count", 32'(out_count), 32'd4);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(out_count), 32'd0);
        chk("arst_instr", out_instr, 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_step", out_pc_step, 32'd0);
        chk("arst_addr", imem_addr, RPC);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("post_arst_pc", out_pc, RPC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
